mem_port_arbiter: RTL and testbench

Sequential arbiter sharing one single-ported unified instruction/data memory between the Fetch stage (PCF) and the Memory stage (loads/stores) of the pipelined MIPS core. It serialises accesses, data first, and drives one pipeline-wide freeze, `MemStall`, alongside the hazard unit's stall/flush signals. Fetched instructions and load data come from registers held inside the arbiter until the pipeline advances.

---
 rtl/mips_mem_pkg.sv | 20 ++
 rtl/ifetch_buf.sv | 62 ++++++
 rtl/mem_port_arbiter.sv | 212 +++++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_mem_pkg.sv
// -----------------------------------------------------------------------------
// mips_mem_pkg
// Shared types and defaults for the single-port memory arbiter of the
// pipelined MIPS core.
//   arb_state_e  : arbiter FSM state encoding
//   DEF_DATA_W   : default memory word width
//   DEF_ADDR_W   : default byte address width
// -----------------------------------------------------------------------------
package mips_mem_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_ADDR_W = 32;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,   // no access in flight
        ARB_D_ACC = 2'd1,   // load/store in flight
        ARB_I_ACC = 2'd2    // instruction fetch in flight
    } arb_state_e;

endpackage : mips_mem_pkg

// File: rtl/ifetch_buf.sv
// -----------------------------------------------------------------------------
// ifetch_buf
// One-entry instruction buffer (valid, address, data) used by
// mem_port_arbiter when ARB_IBUF_EN is defined. It lets a hazard-stalled
// refetch of the same PC complete without touching memory.
// Ports:
//   clk, reset    : clock, synchronous active-high reset
//   i_load        : fetch completed this cycle; capture address and data
//   i_load_addr   : address of the completed fetch
//   i_load_data   : instruction word returned by memory
//   i_inval_req   : a store completed this cycle
//   i_inval_addr  : address of that store (snooped against the entry)
//   i_pc          : current fetch address
//   o_hit         : entry valid and its address equals i_pc
//   o_data        : buffered instruction word
// -----------------------------------------------------------------------------
module ifetch_buf
    import mips_mem_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_load,
    input  logic [ADDR_W-1:0] i_load_addr,
    input  logic [DATA_W-1:0] i_load_data,
    input  logic              i_inval_req,
    input  logic [ADDR_W-1:0] i_inval_addr,
    input  logic [ADDR_W-1:0] i_pc,
    output logic              o_hit,
    output logic [DATA_W-1:0] o_data
);

    logic              r_valid;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_data;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid <= 1'b0;
        end else if (i_load) begin
            r_valid <= 1'b1;
        end else if (i_inval_req && (i_inval_addr == r_addr)) begin
            // Self-modifying code: a store over the buffered word kills it.
            r_valid <= 1'b0;
        end
    end

    // NOTE: the address/data storage has no reset; it is only observed
    // through r_valid, so resetting it would add logic for no behaviour.
    always_ff @(posedge clk) begin
        if (i_load) begin
            r_addr <= i_load_addr;
            r_data <= i_load_data;
        end
    end

    assign o_hit  = r_valid && (r_addr == i_pc);
    assign o_data = r_data;

endmodule : ifetch_buf

// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
// Shares one single-ported unified instruction/data memory between the Fetch
// stage and the Memory stage. Accesses are serialised, data first, and a
// single pipeline-wide freeze (MemStall) is raised until every access needed
// by the current pipeline cycle has completed. Fetched instructions and load
// data are held in registers here until the pipeline advances.
//
// Build option: define ARB_IBUF_EN to add a one-entry instruction buffer
// (ifetch_buf) so that refetching the same PC while the pipeline is
// hazard-stalled costs no memory access. Without it every advance refetches.
//
// Ports:
//   clk, reset              : clock, synchronous active-high reset
//   IfetchReqF, PCF         : fetch request and address
//   MemReadM, MemWriteM     : load/store request (never both high)
//   ALUOutM, WriteDataM     : data address and store data
//   InstrF                  : fetched instruction
//   ReadDataM               : load result
//   MemStall                : freeze all pipeline registers
//   mem_req, mem_we         : memory request / write strobe
//   mem_addr, mem_wdata     : memory address / write data
//   mem_ready, mem_rdata    : memory completion / read data
// -----------------------------------------------------------------------------
module mem_port_arbiter
    import mips_mem_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              IfetchReqF,
    input  logic [ADDR_W-1:0] PCF,
    input  logic              MemReadM,
    input  logic              MemWriteM,
    input  logic [ADDR_W-1:0] ALUOutM,
    input  logic [DATA_W-1:0] WriteDataM,
    output logic [DATA_W-1:0] InstrF,
    output logic [DATA_W-1:0] ReadDataM,
    output logic              MemStall,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ready,
    input  logic [DATA_W-1:0] mem_rdata
);

    arb_state_e        r_state;
    arb_state_e        w_state_next;

    logic              r_d_done;
    logic              r_i_done;
    logic              r_mem_we;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_wdata;
    logic [DATA_W-1:0] r_instr;
    logic [DATA_W-1:0] r_read_data;

    logic              w_data_pend;
    logic              w_fetch_pend;
    logic              w_stall;
    logic              w_launch_d;
    logic              w_launch_i;
    logic              w_d_cmpl;
    logic              w_i_cmpl;
    logic              w_ibuf_hit;

    // -------------------------------------------------------------------------
    // Optional instruction buffer
    // -------------------------------------------------------------------------
`ifdef ARB_IBUF_EN
    logic [DATA_W-1:0] w_ibuf_data;

    ifetch_buf #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_ifetch_buf (
        .clk          (clk),
        .reset        (reset),
        .i_load       (w_i_cmpl),
        .i_load_addr  (r_mem_addr),
        .i_load_data  (mem_rdata),
        .i_inval_req  (w_d_cmpl && r_mem_we),
        .i_inval_addr (r_mem_addr),
        .i_pc         (PCF),
        .o_hit        (w_ibuf_hit),
        .o_data       (w_ibuf_data)
    );

    assign InstrF = w_ibuf_hit ? w_ibuf_data : r_instr;
`else
    assign w_ibuf_hit = 1'b0;
    assign InstrF     = r_instr;
`endif

    // -------------------------------------------------------------------------
    // Pending conditions and the pipeline freeze. The done flags remember
    // which accesses of the current (frozen) pipeline cycle are already served.
    // -------------------------------------------------------------------------
    assign w_data_pend  = (MemReadM || MemWriteM) && !r_d_done;
    assign w_fetch_pend = IfetchReqF && !r_i_done && !w_ibuf_hit;
    assign w_stall      = w_data_pend || w_fetch_pend;
    assign MemStall     = w_stall;

    // -------------------------------------------------------------------------
    // FSM: state register
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ARB_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // -------------------------------------------------------------------------
    // FSM: next state and access strobes. Data wins over fetch in IDLE.
    // -------------------------------------------------------------------------
    // NOTE: every output of this block is defaulted first so no path leaves
    // one unassigned (which would infer a latch).
    always_comb begin
        w_state_next = r_state;
        w_launch_d   = 1'b0;
        w_launch_i   = 1'b0;
        w_d_cmpl     = 1'b0;
        w_i_cmpl     = 1'b0;
        unique case (r_state)
            ARB_IDLE: begin
                if (w_data_pend) begin
                    w_state_next = ARB_D_ACC;
                    w_launch_d   = 1'b1;
                end else if (w_fetch_pend) begin
                    w_state_next = ARB_I_ACC;
                    w_launch_i   = 1'b1;
                end
            end
            ARB_D_ACC: begin
                if (mem_ready) begin
                    w_state_next = ARB_IDLE;
                    w_d_cmpl     = 1'b1;
                end
            end
            ARB_I_ACC: begin
                if (mem_ready) begin
                    w_state_next = ARB_IDLE;
                    w_i_cmpl     = 1'b1;
                end
            end
            default: begin
                w_state_next = ARB_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Request registers, result registers and done flags
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_instr     <= '0;
            r_read_data <= '0;
            r_d_done    <= 1'b0;
            r_i_done    <= 1'b0;
        end else begin
            // Request fields are latched once at launch and held for the
            // whole access, independent of later input changes.
            if (w_launch_d) begin
                r_mem_addr  <= ALUOutM;
                r_mem_we    <= MemWriteM;
                r_mem_wdata <= WriteDataM;
            end else if (w_launch_i) begin
                r_mem_addr  <= PCF;
                r_mem_we    <= 1'b0;
            end

            if (w_d_cmpl && !r_mem_we) begin
                r_read_data <= mem_rdata;
            end
            if (w_i_cmpl) begin
                r_instr <= mem_rdata;
            end

            // A completion always happens with MemStall high, so the clear on
            // an advance cycle never collides with a set.
            if (!w_stall) begin
                r_d_done <= 1'b0;
                r_i_done <= 1'b0;
            end else begin
                if (w_d_cmpl) begin
                    r_d_done <= 1'b1;
                end
                if (w_i_cmpl) begin
                    r_i_done <= 1'b1;
                end
            end
        end
    end

    assign mem_req   = (r_state != ARB_IDLE);
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign ReadDataM = r_read_data;

endmodule : mem_port_arbiter

// File: tb/tb_mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_port_arbiter
// Directed bench for mem_port_arbiter. A small memory responder returns fixed
// words per address after a programmable number of wait cycles. Tests that
// depend on the instruction buffer follow ARB_IBUF_EN.
// -----------------------------------------------------------------------------
module tb_mem_port_arbiter;

    localparam int DW = 32;
    localparam int AW = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic          IfetchReqF;
    logic [AW-1:0] PCF;
    logic          MemReadM;
    logic          MemWriteM;
    logic [AW-1:0] ALUOutM;
    logic [DW-1:0] WriteDataM;
    logic [DW-1:0] InstrF;
    logic [DW-1:0] ReadDataM;
    logic          MemStall;
    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_ready;
    logic [DW-1:0] mem_rdata;

    int errors   = 0;
    int checks   = 0;
    int lat      = 0;
    int wait_cnt = 0;
    int acc_cnt  = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .DATA_W (DW),
        .ADDR_W (AW)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .IfetchReqF (IfetchReqF),
        .PCF        (PCF),
        .MemReadM   (MemReadM),
        .MemWriteM  (MemWriteM),
        .ALUOutM    (ALUOutM),
        .WriteDataM (WriteDataM),
        .InstrF     (InstrF),
        .ReadDataM  (ReadDataM),
        .MemStall   (MemStall),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_ready  (mem_ready),
        .mem_rdata  (mem_rdata)
    );

    // Fixed memory contents for the addresses the tests touch.
    function automatic logic [DW-1:0] rd_model(input logic [AW-1:0] a);
        case (a)
            32'h0000_0000: rd_model = 32'h2008_0005;
            32'h0000_0008: rd_model = 32'h3333_4444;
            32'h0000_0010: rd_model = 32'h5555_6666;
            32'h0000_0020: rd_model = 32'h9999_0000;
            32'h0000_0040: rd_model = 32'h1111_2222;
            32'h0000_0048: rd_model = 32'h7777_8888;
            default:       rd_model = 32'hBAD0_BAD0;
        endcase
    endfunction

    // Memory responder: ready after 'lat' wait cycles of a held request.
    assign mem_ready = mem_req && (wait_cnt >= lat);
    assign mem_rdata = rd_model(mem_addr);

    always @(posedge clk) begin
        if (mem_req && !mem_ready) wait_cnt <= wait_cnt + 1;
        else                       wait_cnt <= 0;
        if (mem_req && mem_ready)  acc_cnt  <= acc_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance one clock; outputs are sampled 1 time unit after the edge.
    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        IfetchReqF = 1'b0;
        PCF        = '0;
        MemReadM   = 1'b0;
        MemWriteM  = 1'b0;
        ALUOutM    = '0;
        WriteDataM = '0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int stall_cnt;
        int acc_snap;

        clear_inputs();
        reset = 1'b1;
        cycle();
        cycle();
        reset = 1'b0;
        #1;

        // ---------------- reset state ----------------
        check("rst_mem_req",   32'(mem_req),   32'd0);
        check("rst_mem_we",    32'(mem_we),    32'd0);
        check("rst_mem_addr",  mem_addr,       32'd0);
        check("rst_mem_wdata", mem_wdata,      32'd0);
        check("rst_instr",     InstrF,         32'd0);
        check("rst_rdata",     ReadDataM,      32'd0);
        check("rst_no_req_stall", 32'(MemStall), 32'd0);
        cycle();
        check("idle_no_access", 32'(mem_req), 32'd0);

        // ---------------- fetch only, zero wait ----------------
        lat = 0;
        IfetchReqF = 1'b1;
        PCF        = 32'h0;
        #1;
        check("f_c0_stall", 32'(MemStall), 32'd1);
        check("f_c0_req",   32'(mem_req),  32'd0);
        cycle();
        check("f_c1_stall", 32'(MemStall), 32'd1);
        check("f_c1_req",   32'(mem_req),  32'd1);
        check("f_c1_we",    32'(mem_we),   32'd0);
        check("f_c1_addr",  mem_addr,      32'h0);
        cycle();
        check("f_c2_stall", 32'(MemStall), 32'd0);
        check("f_c2_instr", InstrF,        32'h2008_0005);
        clear_inputs();
        cycle();

        // ---------------- load + fetch in one pipeline cycle ----------------
        MemReadM   = 1'b1;
        ALUOutM    = 32'h40;
        IfetchReqF = 1'b1;
        PCF        = 32'h8;
        stall_cnt  = 0;
        #1;
        check("lf_c0_stall", 32'(MemStall), 32'd1);
        cycle();
        stall_cnt += int'(MemStall);
        check("lf_c1_req",  32'(mem_req), 32'd1);
        check("lf_c1_addr", mem_addr,     32'h40);
        check("lf_c1_we",   32'(mem_we),  32'd0);
        cycle();
        stall_cnt += int'(MemStall);
        check("lf_c2_req",   32'(mem_req), 32'd0);
        check("lf_c2_rdata", ReadDataM,    32'h1111_2222);
        cycle();
        stall_cnt += int'(MemStall);
        check("lf_c3_req",  32'(mem_req), 32'd1);
        check("lf_c3_addr", mem_addr,     32'h8);
        cycle();
        stall_cnt += int'(MemStall);
        check("lf_stall_cycles", 32'(stall_cnt), 32'd3);
        check("lf_c4_instr", InstrF,    32'h3333_4444);
        check("lf_c4_rdata", ReadDataM, 32'h1111_2222);
        clear_inputs();
        cycle();

        // ---------------- store ----------------
        MemWriteM  = 1'b1;
        ALUOutM    = 32'h44;
        WriteDataM = 32'hDEAD_BEEF;
        #1;
        check("st_c0_stall", 32'(MemStall), 32'd1);
        cycle();
        check("st_c1_req",   32'(mem_req), 32'd1);
        check("st_c1_we",    32'(mem_we),  32'd1);
        check("st_c1_addr",  mem_addr,     32'h44);
        check("st_c1_wdata", mem_wdata,    32'hDEAD_BEEF);
        cycle();
        check("st_c2_stall", 32'(MemStall), 32'd0);
        check("st_rdata_kept", ReadDataM,   32'h1111_2222);
        clear_inputs();
        cycle();

        // ---------------- load with 5 wait cycles ----------------
        lat      = 5;
        MemReadM = 1'b1;
        ALUOutM  = 32'h48;
        #1;
        cycle();
        for (int i = 1; i <= 5; i++) begin
            check($sformatf("wt_req_%0d", i),   32'(mem_req),  32'd1);
            check($sformatf("wt_stall_%0d", i), 32'(MemStall), 32'd1);
            check($sformatf("wt_addr_%0d", i),  mem_addr,      32'h48);
            cycle();
        end
        check("wt_ready_req", 32'(mem_req), 32'd1);
        cycle();
        check("wt_done_stall", 32'(MemStall), 32'd0);
        check("wt_rdata",      ReadDataM,     32'h7777_8888);
        clear_inputs();
        cycle();

        // ---------------- reset during I_ACC ----------------
        lat        = 10;
        IfetchReqF = 1'b1;
        PCF        = 32'h20;
        #1;
        cycle();
        check("rs_in_iacc", 32'(mem_req), 32'd1);
        reset = 1'b1;
        cycle();
        check("rs_req_drop", 32'(mem_req), 32'd0);
        check("rs_instr",    InstrF,       32'd0);
        check("rs_rdata",    ReadDataM,    32'd0);
        reset = 1'b0;
        clear_inputs();
        cycle();

        // ---------------- hazard-stalled refetch of the same PC ----------------
        lat        = 0;
        acc_snap   = acc_cnt;
        IfetchReqF = 1'b1;
        PCF        = 32'h10;
        #1;
        cycle();
        check("hz_c1_addr", mem_addr, 32'h10);
        cycle();
        check("hz_c2_stall", 32'(MemStall), 32'd0);
        check("hz_c2_instr", InstrF,        32'h5555_6666);
        cycle();    // same PC presented again after the advance
`ifdef ARB_IBUF_EN
        check("hz_hit_stall", 32'(MemStall), 32'd0);
        check("hz_hit_instr", InstrF,        32'h5555_6666);
        cycle();
        check("hz_accesses", 32'(acc_cnt - acc_snap), 32'd1);
`else
        check("hz_refetch_stall", 32'(MemStall), 32'd1);
        cycle();
        check("hz_refetch_req", 32'(mem_req), 32'd1);
        cycle();
        check("hz_refetch_done", 32'(MemStall), 32'd0);
        check("hz_accesses", 32'(acc_cnt - acc_snap), 32'd2);
`endif
        clear_inputs();
        cycle();

        // ---------------- store to 0x10 forces a real refetch ----------------
        MemWriteM  = 1'b1;
        ALUOutM    = 32'h10;
        WriteDataM = 32'h0;
        #1;
        cycle();
        cycle();
        check("sm_st_done", 32'(MemStall), 32'd0);
        clear_inputs();
        cycle();
        acc_snap   = acc_cnt;
        IfetchReqF = 1'b1;
        PCF        = 32'h10;
        #1;
        check("sm_refetch_stall", 32'(MemStall), 32'd1);
        cycle();
        check("sm_refetch_req",  32'(mem_req), 32'd1);
        check("sm_refetch_addr", mem_addr,     32'h10);
        cycle();
        check("sm_refetch_acc", 32'(acc_cnt - acc_snap), 32'd1);
        clear_inputs();
        cycle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_mem_port_arbiter
